// File: rtl/game_pkg.sv
// Shared game constants and the missile controller state encoding.
// Default parameter values live here so every block agrees on them.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } state_e;

  localparam int STEP_DIV_D  = 1000;
  localparam int STEP_D      = 4;
  localparam int COOLDOWN_D  = 2000;
  localparam int X_OFFSET_D  = 20;
  localparam int MISSILE_H_D = 16;
  localparam int Y_TOP_D     = 0;

endpackage

// File: rtl/ctl_missile_pl_if.sv
// Player-side inputs and missile sprite outputs of the missile controller.
// master drives the player/enemy inputs, slave is the controller.
interface ctl_missile_pl_if;

  logic        fire_btn;
  logic [10:0] xpos_player;
  logic [10:0] ypos_player;
  logic        hit;
  logic [10:0] xpos_missile;
  logic [10:0] ypos_missile;
  logic        on_missile;

  modport master (
    output fire_btn, xpos_player, ypos_player, hit,
    input  xpos_missile, ypos_missile, on_missile
  );

  modport slave (
    input  fire_btn, xpos_player, ypos_player, hit,
    output xpos_missile, ypos_missile, on_missile
  );

endinterface

// File: rtl/ctl_missile_pl_tick_gen.sv
// Step-rate divider: counts enabled cycles, pulses tick on the last one.
// clr restarts the period so a fresh flight gets a full first step.
module tick_gen #(
  parameter int DIV = game_pkg::STEP_DIV_D
) (
  input  logic pclk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [31:0] cnt_q;

  assign tick = en && (cnt_q == 32'(DIV - 1));

  // period counter, wraps to 0 after the tick cycle
  always_ff @(posedge pclk) begin
    if (rst || clr)
      cnt_q <= '0;
    else if (en)
      cnt_q <= tick ? '0 : cnt_q + 32'd1;
  end

endmodule

// File: rtl/ctl_missile_pl.sv
// Player missile controller: launch on fire edge, climb in steps,
// end on hit or top of screen, then hold off relaunch for a cooldown.
module ctl_missile_pl
  import game_pkg::*;
#(
  parameter int STEP_DIV  = STEP_DIV_D,
  parameter int STEP      = STEP_D,
  parameter int COOLDOWN  = COOLDOWN_D,
  parameter int X_OFFSET  = X_OFFSET_D,
  parameter int MISSILE_H = MISSILE_H_D,
  parameter int Y_TOP     = Y_TOP_D
) (
  input  logic pclk,
  input  logic rst,
  ctl_missile_pl_if.slave bus
);

  localparam logic [10:0] X_OFF   = 11'(X_OFFSET);
  localparam logic [10:0] H_OFF   = 11'(MISSILE_H);
  localparam logic [10:0] STEP_PX = 11'(STEP);
  localparam logic [10:0] Y_MIN_L = 11'(MISSILE_H + Y_TOP);
  localparam logic [10:0] Y_MIN_S = 11'(Y_TOP + STEP);
  localparam logic [31:0] CD_LOAD = 32'(COOLDOWN - 1);

  state_e      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        on_q, on_d;
  logic [31:0] cool_q, cool_d;
  logic        btn_q;
  logic        fire_rise;
  logic        launch;
  logic        tick;

  assign fire_rise = bus.fire_btn & ~btn_q;

  tick_gen #(
    .DIV (STEP_DIV)
  ) u_tick (
    .pclk (pclk),
    .rst  (rst),
    .clr  (launch),
    .en   (state_q == FLY),
    .tick (tick)
  );

  // button history resets high so a button held through reset never fires
  always_ff @(posedge pclk) begin
    if (rst)
      btn_q <= 1'b1;
    else
      btn_q <= bus.fire_btn;
  end

  // state, missile position and cooldown registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      on_q    <= 1'b0;
      cool_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      on_q    <= on_d;
      cool_q  <= cool_d;
    end
  end

  // next state; hit beats a simultaneous step tick
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    on_d    = on_q;
    cool_d  = cool_q;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire_rise && (bus.ypos_player >= Y_MIN_L)) begin
          state_d = FLY;
          x_d     = bus.xpos_player + X_OFF;
          y_d     = bus.ypos_player - H_OFF;
          on_d    = 1'b1;
          launch  = 1'b1;
        end
      end
      FLY: begin
        if (bus.hit) begin
          state_d = COOL;
          on_d    = 1'b0;
          cool_d  = CD_LOAD;
        end else if (tick) begin
          if (y_q >= Y_MIN_S) begin
            y_d = y_q - STEP_PX;
          end else begin
            state_d = COOL;
            on_d    = 1'b0;
            cool_d  = CD_LOAD;
          end
        end
      end
      COOL: begin
        if (cool_q == '0)
          state_d = IDLE;
        else
          cool_d = cool_q - 32'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.xpos_missile = x_q;
  assign bus.ypos_missile = y_q;
  assign bus.on_missile   = on_q;

endmodule

// File: tb/tb_ctl_missile_pl.sv
// Directed and randomized bench for ctl_missile_pl against a
// cycle-level behavioural model of the missile's flight.
module tb_ctl_missile_pl;

  localparam int SDIV = 4;
  localparam int STP  = 2;
  localparam int CD   = 8;
  localparam int XOFF = 20;
  localparam int MH   = 16;
  localparam int YT   = 0;

  logic pclk;
  logic rst;
  ctl_missile_pl_if bus ();

  ctl_missile_pl #(
    .STEP_DIV  (SDIV),
    .STEP      (STP),
    .COOLDOWN  (CD),
    .X_OFFSET  (XOFF),
    .MISSILE_H (MH),
    .Y_TOP     (YT)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  // model: alive missile, its position, cycles flown, cooldown left
  bit m_alive;
  int m_x, m_y;
  int m_flown;
  int m_cool;
  bit m_prev;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic model_step();
    bit req;
    if (rst) begin
      m_alive = 0;
      m_x = 0;
      m_y = 0;
      m_flown = 0;
      m_cool = 0;
      m_prev = 1;
    end else begin
      req = bus.fire_btn && !m_prev;
      m_prev = bus.fire_btn;
      if (m_cool > 0) begin
        m_cool--;
      end else if (m_alive) begin
        if (bus.hit) begin
          m_alive = 0;
          m_cool = CD;
        end else begin
          m_flown++;
          if (m_flown == SDIV) begin
            m_flown = 0;
            if (m_y >= YT + STP) m_y -= STP;
            else begin
              m_alive = 0;
              m_cool = CD;
            end
          end
        end
      end else if (req && int'(bus.ypos_player) >= MH + YT) begin
        m_alive = 1;
        m_x = (int'(bus.xpos_player) + XOFF) % 2048;
        m_y = int'(bus.ypos_player) - MH;
        m_flown = 0;
      end
    end
  endtask

  // one clock: model follows the edge, outputs checked 1 time unit later
  task automatic step();
    @(posedge pclk);
    model_step();
    #1;
    chk("on", 32'(bus.on_missile), 32'(m_alive));
    chk("x", 32'(bus.xpos_missile), 32'(m_x));
    chk("y", 32'(bus.ypos_missile), 32'(m_y));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic lit(input string nm, input int on, input int x,
                     input int y);
    chk({nm, "_on"}, 32'(bus.on_missile), 32'(on));
    chk({nm, "_x"}, 32'(bus.xpos_missile), 32'(x));
    chk({nm, "_y"}, 32'(bus.ypos_missile), 32'(y));
    chk({nm, "_mdl_y"}, 32'(m_y), 32'(y));
  endtask

  task automatic set_player(input int x, input int y);
    bus.xpos_player = 11'(x);
    bus.ypos_player = 11'(y);
  endtask

  initial begin
    rst = 1'b1;
    bus.fire_btn = 1'b0;
    bus.hit = 1'b0;
    set_player(100, 400);
    steps(2);
    lit("reset", 0, 0, 0);
    rst = 1'b0;
    step();

    // launch and two steps of climb
    bus.fire_btn = 1'b1;
    step();
    lit("launch", 1, 120, 384);
    bus.fire_btn = 1'b0;
    steps(4);
    lit("step1", 1, 120, 382);
    steps(4);
    lit("step2", 1, 120, 380);

    // hit coinciding with a tick at y=200
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    set_player(50, 216);
    bus.fire_btn = 1'b1;
    step();
    lit("l200", 1, 70, 200);
    bus.fire_btn = 1'b0;
    steps(3);
    bus.hit = 1'b1;
    step();
    bus.hit = 1'b0;
    lit("hit", 0, 70, 200);
    steps(CD);

    // top-of-screen end, press during cooldown, press after it
    set_player(10, 19);
    bus.fire_btn = 1'b1;
    step();
    lit("l3", 1, 30, 3);
    bus.fire_btn = 1'b0;
    steps(4);
    lit("y1", 1, 30, 1);
    steps(4);
    lit("top", 0, 30, 1);
    steps(3);
    bus.fire_btn = 1'b1;
    step();
    lit("cool4", 0, 30, 1);
    bus.fire_btn = 1'b0;
    steps(4);
    bus.fire_btn = 1'b1;
    step();
    lit("relaunch", 1, 30, 3);

    // button held across reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(3);
    lit("held", 0, 0, 0);
    bus.fire_btn = 1'b0;
    step();
    set_player(2040, 300);
    bus.fire_btn = 1'b1;
    step();
    lit("repress", 1, 12, 284);

    // reset during flight, then too-low player
    rst = 1'b1;
    step();
    lit("rstfly", 0, 0, 0);
    rst = 1'b0;
    bus.fire_btn = 1'b0;
    step();
    set_player(100, 10);
    bus.fire_btn = 1'b1;
    step();
    lit("low", 0, 0, 0);

    // randomized play
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.fire_btn = ~bus.fire_btn;
      bus.hit = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0)
        set_player($urandom_range(0, 2047),
                   ($urandom_range(0, 3) == 0) ?
                     $urandom_range(0, 2047) : $urandom_range(0, 40));
      rst = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
